fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter and two-stage pipeline that shares one single-precision floating-point multiplier instance (`multiplier`) between NREQ requesters, e.g. the neuron lanes of the MLP datapath. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning pair and drives the combinational multiplier from those registers. It returns the product, the multiplier's exception/overflow/underflow flags and the requester index on a single valid/ready response port.

## Interface
- NREQ, 4: number of requesters, 2..16.
- IDW, $clog2(NREQ): width of the requester index.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  request valid, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle, one-hot or zero.
- req_a  input  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- req_b  input  32*NREQ  operand B; same packing as req_a.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  IDW  index of the requester that owns the response.
- resp_prod  output  32  product from the multiplier.
- resp_flags  output  3  {exception, overflow, underflow} from the multiplier.
- flag_count  output  16  count of flagged results; see Configuration.

## Operation
- Stage S1 registers: s1_valid, s1_a, s1_b, s1_id. Stage S2 registers: s2_valid, s2_prod, s2_flags, s2_id.
- resp_* outputs are driven directly from the S2 registers; resp_valid = s2_valid.
- Advance conditions:
  - s2_adv = !s2_valid | resp_ready.
  - s1_adv = !s1_valid | s2_adv.
- Arbitration:
  - Round-robin pointer `ptr` (IDW bits). The candidate order is ptr, ptr+1, …, wrapping modulo NREQ.
  - The first requester in that order with req_valid set wins.
  - req_ready[i] = s1_adv & (i == winner).
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On a handshake (req_valid[i] & req_ready[i]):
  - S1 loads req_a/req_b slice i, s1_id = i, s1_valid = 1.
  - ptr is set to (i+1) mod NREQ.
  - Wrap rule: i = NREQ-1 sets ptr to 0.
- If s1_adv is set and no requester is valid, s1_valid is cleared. ptr holds.
- The multiplier is fed from s1_a/s1_b. When s2_adv & s1_valid, S2 captures prod, the three flags and s1_id, and s2_valid is set.
- If s2_adv is set and s1_valid is clear, s2_valid is cleared. S2 data holds.
- With resp_valid set and resp_ready low, all of resp_* are held stable.
- Responses come out in acceptance order. No reordering and no drop.
- Simultaneous events:
  - resp handshake, S1→S2 move and a new request acceptance can all occur in the same cycle.
  - Full throughput is one result per cycle.
- Reset:
  - Clears s1_valid, s2_valid, ptr and flag_count.
  - Clears resp_prod, resp_flags and resp_id to 0.
  - In-flight operations are discarded with no response.
  - req_ready is 0 while rst is asserted.

## Timing
- Reset values: resp_valid=0, resp_id=0, resp_prod=0, resp_flags=0, flag_count=0, req_ready=0.
- Latency: for a handshake in cycle k with no backpressure, resp_valid is high in cycle k+2 with that operation's result.
- Stall: resp_ready low with both stages full forces req_ready to all-zero in the same cycle.
- One resp_ready high cycle re-opens exactly one acceptance slot in that same cycle.
- Fairness: with all NREQ valid continuously and resp_ready high, grants rotate 0,1,…,NREQ-1,0,… and each requester is served once every NREQ cycles.

## Configuration
- FPMUL_ARB_FLAGCNT_EN defined:
  - flag_count increments by 1 on each response handshake (resp_valid & resp_ready) whose resp_flags is non-zero.
  - It saturates at 16'hFFFF.
  - It is cleared only by rst.
- FPMUL_ARB_FLAGCNT_EN undefined: flag_count is tied to 16'h0000 and no counter logic is built.

## Test plan
- Single request, NREQ=4:
  - Stimulus: after reset, requester 2 holds 0x40000000 × 0x40400000, resp_ready=1.
  - Response: req_ready=4'b0100 for one cycle; resp_valid two cycles later with resp_id=2; resp_prod/resp_flags bit-equal to a standalone `multiplier` fed the same operands.
- Round-robin:
  - Stimulus: all four requesters valid continuously, resp_ready=1.
  - Response: grant order 0,1,2,3,0,1; resp_id sequence identical, one response per cycle after a 2-cycle fill.
- Backpressure:
  - Stimulus: accept ops from requesters 0 and 1, then hold resp_ready=0 for 5 cycles.
  - Response: resp_* stable through the stall, req_ready=0 while both stages are full; on release, resp_id 0 then 1 on consecutive cycles with no loss or duplication.
- Exception flag, with FPMUL_ARB_FLAGCNT_EN:
  - Stimulus: A=0x7F800000, B=0x3F800000, then two normal ops.
  - Response: first response resp_prod=0x00000000, resp_flags[2]=1; flag_count=1 after its handshake and unchanged afterwards.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously with both stages valid.
  - Response: resp_valid=0 and req_ready=0 immediately; no stale response after release; the first grant after release goes to requester 0 when all are valid.
- Macro off:
  - Stimulus: repeat the exception test without FPMUL_ARB_FLAGCNT_EN.
  - Response: flag_count stays 0x0000; all other outputs identical to the macro-on run.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter plus a two-stage pipeline that shares one
// single-precision multiplier between NREQ requesters.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b         packed operands, requester i owns bits [32i+31:32i]
//   resp_valid/ready    single response handshake, driven from stage S2
//   resp_id/prod/flags  owner index, product, {exception, overflow, underflow}
//   flag_count          number of flagged responses handed off
//
// Optional feature: define FPMUL_ARB_FLAGCNT_EN to build the saturating
// flagged-response counter; otherwise flag_count is tied to zero.

// Combinational IEEE-754 single-precision multiplier. Denormal inputs flush
// to zero, rounding is to nearest-even, any Inf/NaN operand raises exception
// and forces a zero product.
module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] prod,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);
    logic        sign;
    logic [7:0]  ea, eb;
    logic [47:0] mant;
    logic [22:0] keep;
    logic        guard, sticky, round_up;
    logic [23:0] mant_r;
    logic [9:0]  exp_sum;
    logic [7:0]  exp_out;

    always_comb begin
        sign = a[31] ^ b[31];
        ea   = a[30:23];
        eb   = b[30:23];
        mant = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        // Product of two 1.x mantissas lies in [1,4): bit 47 picks the normalisation.
        if (mant[47]) begin
            keep   = mant[46:24];
            guard  = mant[23];
            sticky = |mant[22:0];
        end else begin
            keep   = mant[45:23];
            guard  = mant[22];
            sticky = |mant[21:0];
        end
        round_up = guard & (sticky | keep[0]);
        mant_r   = {1'b0, keep} + {23'd0, round_up};
        // A rounding carry out of the mantissa bumps the exponent; fraction is then zero.
        exp_sum  = {2'b00, ea} + {2'b00, eb} + {9'd0, mant[47]} + {9'd0, mant_r[23]};
        exp_out  = exp_sum[7:0] - 8'd127;

        exception = (&ea) | (&eb);
        overflow  = 1'b0;
        underflow = 1'b0;
        prod      = {sign, exp_out, mant_r[22:0]};
        if (exception) begin
            prod = 32'd0;
        end else if (ea == 8'd0 || eb == 8'd0) begin
            prod = {sign, 31'd0};
        end else if (exp_sum >= 10'd382) begin
            overflow = 1'b1;
            prod     = {sign, 8'hFF, 23'd0};
        end else if (exp_sum <= 10'd127) begin
            underflow = 1'b1;
            prod      = {sign, 31'd0};
        end
    end
endmodule

module fpmul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_prod,
    output logic [2:0]           resp_flags,
    output logic [15:0]          flag_count
);
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [31:0]     s2_prod_q, s2_prod_d;
    logic [2:0]      s2_flags_q, s2_flags_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            s1_adv, s2_adv, found;
    logic [IDW-1:0]  winner;
    int              idx;
    logic [31:0]     mul_prod;
    logic            mul_exc, mul_ovf, mul_unf;

    multiplier u_mul (
        .a         (s1_a_q),
        .b         (s1_b_q),
        .prod      (mul_prod),
        .exception (mul_exc),
        .overflow  (mul_ovf),
        .underflow (mul_unf)
    );

    always_comb begin
        s2_adv = !s2_valid_q || resp_ready;
        s1_adv = !s1_valid_q || s2_adv;

        // Scan ptr, ptr+1, ... (mod NREQ); first valid requester wins.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end

        // Gated by rst so no handshake is offered while reset is held.
        req_ready = '0;
        if (s1_adv && found && !rst) req_ready[winner] = 1'b1;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        ptr_d      = ptr_q;
        if (s1_adv) begin
            s1_valid_d = found;
            if (found) begin
                s1_a_d  = req_a[32*winner +: 32];
                s1_b_d  = req_b[32*winner +: 32];
                s1_id_d = winner;
                ptr_d   = (int'(winner) == NREQ-1) ? '0 : winner + IDW'(1);
            end
        end

        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_flags_d = s2_flags_q;
        s2_id_d    = s2_id_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d  = mul_prod;
                s2_flags_d = {mul_exc, mul_ovf, mul_unf};
                s2_id_d    = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_flags_q <= '0;
            s2_id_q    <= '0;
            ptr_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_flags_q <= s2_flags_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign resp_valid = s2_valid_q;
    assign resp_id    = s2_id_q;
    assign resp_prod  = s2_prod_q;
    assign resp_flags = s2_flags_q;

`ifdef FPMUL_ARB_FLAGCNT_EN
    logic [15:0] flag_count_q, flag_count_d;

    always_comb begin
        flag_count_d = flag_count_q;
        if (s2_valid_q && resp_ready && (s2_flags_q != 3'd0) && (flag_count_q != 16'hFFFF))
            flag_count_d = flag_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flag_count_q <= '0;
        else     flag_count_q <= flag_count_d;
    end

    assign flag_count = flag_count_q;
`else
    assign flag_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: queue-level reference model (capacity-two in-order
// pipe, round-robin pointer, arithmetic float multiply) compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fpmul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef FPMUL_ARB_FLAGCNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic                resp_valid, resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_prod;
    logic [2:0]          resp_flags;
    logic [15:0]         flag_count;

    fpmul_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_prod(resp_prod), .resp_flags(resp_flags),
        .flag_count(flag_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference float multiply: returns {flags, product}.
    function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        longint p, q, rem, half;
        logic s;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'h0};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'h0};
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (longint'(1) << 47)) begin sh = 24; e = e + 1; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
        if (e > 254) return {3'b010, s, 8'hFF, 23'h0};
        if (e < 1)   return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    prod;
        logic [2:0]     flags;
        int             stage;
    } item_t;

    item_t          mq[$];
    logic [IDW-1:0] mptr;
    logic [IDW-1:0] h_id;
    logic [31:0]    h_prod;
    logic [2:0]     h_flags;
    logic [15:0]    mcnt;

    int          dut_grants[$];
    logic [31:0] dr_id[$], dr_prod[$], dr_flags[$];

    // Model and per-cycle compare, evaluated mid-cycle when inputs are stable.
    initial begin
        logic [NREQ-1:0] erdy;
        bit              erv, pop, ok;
        int              g, cand;
        item_t           it;
        logic [34:0]     r;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                mptr = '0; h_id = '0; h_prod = '0; h_flags = '0; mcnt = '0;
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                erv = (mq.size() > 0) && (mq[0].stage == 2);
                chk("resp_valid", 32'(resp_valid), 32'(erv));
                chk("resp_id", 32'(resp_id), 32'(h_id));
                chk("resp_prod", resp_prod, h_prod);
                chk("resp_flags", 32'(resp_flags), 32'(h_flags));
                chk("flag_count", 32'(flag_count), 32'(mcnt));
                pop = erv && resp_ready;
                ok  = (mq.size() < 2) || pop;
                g   = -1;
                for (int k = 0; k < NREQ; k++) begin
                    cand = (int'(mptr) + k) % NREQ;
                    if (g < 0 && req_valid[cand]) g = cand;
                end
                erdy = '0;
                if (ok && g >= 0) erdy[g] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(erdy));

                for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
                if (resp_valid && resp_ready) begin
                    dr_id.push_back(32'(resp_id));
                    dr_prod.push_back(resp_prod);
                    dr_flags.push_back(32'(resp_flags));
                end

                if (pop) begin
`ifdef FPMUL_ARB_FLAGCNT_EN
                    if (mq[0].flags != 3'd0 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
`endif
                    void'(mq.pop_front());
                end
                if (mq.size() > 0 && mq[0].stage == 1) begin
                    it = mq[0];
                    it.stage = 2;
                    mq[0] = it;
                    h_id = it.id; h_prod = it.prod; h_flags = it.flags;
                end
                if (ok && g >= 0) begin
                    r = fmul(req_a[32*g +: 32], req_b[32*g +: 32]);
                    it.id = IDW'(g); it.prod = r[31:0]; it.flags = r[34:32]; it.stage = 1;
                    mq.push_back(it);
                    mptr = (g == NREQ-1) ? '0 : IDW'(g + 1);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic clear_logs;
        dut_grants.delete(); dr_id.delete(); dr_prod.delete(); dr_flags.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        step; step;
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_id", 32'(resp_id), 32'd0);
        chk("reset_resp_prod", resp_prod, 32'd0);
        chk("reset_resp_flags", 32'(resp_flags), 32'd0);
        chk("reset_flag_count", 32'(flag_count), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        clear_logs();
        rst = 1'b0;
    endtask

    logic [34:0] pin;
    logic [31:0] hold_prod;
    logic [31:0] ta[7], tb_[7];
    int          tr[7];
    int          rr_exp[6];

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;

        // Pin the reference multiply with hand-computed results.
        pin = fmul(32'h40000000, 32'h40400000); chk("pin_2x3", 32'(pin), 32'h40C00000);
        pin = fmul(32'h7F800000, 32'h3F800000); chk("pin_inf", {pin[34:32], pin[31:3]}, {3'b100, 29'd0});
        pin = fmul(32'h3FC00000, 32'h3FC00000); chk("pin_1p5sq", 32'(pin), 32'h40100000);
        pin = fmul(32'h3FFFFFFF, 32'h3F800001); chk("pin_carry", 32'(pin), 32'h40000000);
        pin = fmul(32'h7F000000, 32'h7F000000); chk("pin_ovf", 32'(pin[34:32]), 32'd2);

        @(posedge clk); #1;

        // Single request from requester 2.
        do_reset();
        set_op(2, 32'h40000000, 32'h40400000);
        req_valid = 4'b0100; resp_ready = 1'b1; #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        step; req_valid = '0; #1;
        chk("single_ready_off", 32'(req_ready), 32'h0);
        step;
        chk("single_rv", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd2);
        chk("single_prod", resp_prod, 32'h40C00000);
        chk("single_flags", 32'(resp_flags), 32'd0);
        step;
        chk("single_rv_off", 32'(resp_valid), 32'd0);

        // Round-robin with all requesters valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000 + (i << 21), 32'h40000000 + (i << 20));
        req_valid = 4'hF; resp_ready = 1'b1;
        repeat (8) step;
        req_valid = '0;
        repeat (4) step;
        rr_exp = '{0, 1, 2, 3, 0, 1};
        chk("rr_grant_cnt", 32'(dut_grants.size()), 32'd8);
        chk("rr_resp_cnt", 32'(dr_id.size()), 32'd8);
        for (int i = 0; i < 6; i++) begin
            if (i < dut_grants.size()) chk("rr_grant", 32'(dut_grants[i]), 32'(rr_exp[i]));
            if (i < dr_id.size())      chk("rr_resp_id", dr_id[i], 32'(rr_exp[i]));
        end

        // Backpressure: two ops in flight, consumer stalls five cycles.
        do_reset();
        set_op(0, 32'h40000000, 32'h40000000);
        set_op(1, 32'h40400000, 32'h40400000);
        set_op(2, 32'h40800000, 32'h3F000000);
        req_valid = 4'b0011; resp_ready = 1'b0; step;
        req_valid = 4'b0010; step;
        req_valid = 4'b0100; #1;
        chk("bp_rv", 32'(resp_valid), 32'd1);
        chk("bp_stall_ready", 32'(req_ready), 32'd0);
        hold_prod = resp_prod;
        repeat (4) begin
            step;
            chk("bp_hold_id", 32'(resp_id), 32'd0);
            chk("bp_hold_prod", resp_prod, hold_prod);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        step;
        resp_ready = 1'b1; #1;
        chk("bp_reopen", 32'(req_ready), 32'h4);
        step; req_valid = '0;
        repeat (4) step;
        chk("bp_resp_cnt", 32'(dr_id.size()), 32'd3);
        if (dr_id.size() == 3) begin
            chk("bp_id0", dr_id[0], 32'd0);
            chk("bp_id1", dr_id[1], 32'd1);
            chk("bp_id2", dr_id[2], 32'd2);
            chk("bp_prod0", dr_prod[0], 32'h40800000);
        end

        // Exception, overflow, underflow and rounding vectors.
        do_reset();
        ta  = '{32'h7F800000, 32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h3FFFFFFF, 32'h3FFFFFFF};
        tb_ = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h3F800001, 32'h3FFFFFFF};
        tr  = '{0, 1, 2, 3, 0, 1, 2};
        resp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            set_op(tr[c], ta[c], tb_[c]);
            req_valid = '0;
            req_valid[tr[c]] = 1'b1;
            #1;
            if (c == 3 || c == 5) chk("exc_flag_count", 32'(flag_count), 32'(FC_ON));
            step;
        end
        req_valid = '0;
        repeat (4) step;
        chk("exc_resp_cnt", 32'(dr_id.size()), 32'd7);
        if (dr_id.size() == 7) begin
            chk("exc_prod", dr_prod[0], 32'h00000000);
            chk("exc_flags", dr_flags[0], 32'd4);
            chk("norm_prod", dr_prod[1], 32'h40C00000);
            chk("sq_prod", dr_prod[2], 32'h40100000);
            chk("ovf_prod", dr_prod[3], 32'h7F800000);
            chk("ovf_flags", dr_flags[3], 32'd2);
            chk("unf_flags", dr_flags[4], 32'd1);
            chk("carry_prod", dr_prod[5], 32'h40000000);
            chk("rne_prod", dr_prod[6], 32'h407FFFFE);
        end
        chk("final_flag_count", 32'(flag_count), 32'(3 * FC_ON));

        // Asynchronous reset with both stages occupied.
        do_reset();
        set_op(0, 32'h3FC00000, 32'h3FC00000);
        set_op(1, 32'h40000000, 32'h40000000);
        req_valid = 4'b0011; resp_ready = 1'b0; step;
        req_valid = 4'b0010; step;
        req_valid = 4'hF; #1;
        rst = 1'b1; #1;
        chk("arst_rv", 32'(resp_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        clear_logs();
        set_op(0, 32'h40000000, 32'h40400000);
        step;
        rst = 1'b0; resp_ready = 1'b1; #1;
        chk("arst_first_grant", 32'(req_ready), 32'h1);
        step; req_valid = '0;
        repeat (4) step;
        chk("arst_resp_cnt", 32'(dr_id.size()), 32'd1);
        if (dr_id.size() == 1) begin
            chk("arst_resp_id", dr_id[0], 32'd0);
            chk("arst_resp_prod", dr_prod[0], 32'h40C00000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
